// File: rtl/operand_stage.sv
// Decode-to-execute issue stage: register file read, pending-write scoreboard and registered handoff.
// Optional same-cycle writeback bypass is enabled by defining OPERAND_BYPASS_EN.
module operand_stage #(
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_wen,
    input  logic [CTRL_W-1:0] in_ctrl,

    output logic [4:0]        rf_addr_a,
    output logic [4:0]        rf_addr_b,
    input  logic [31:0]       rf_data_a,
    input  logic [31:0]       rf_data_b,

    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_op_a,
    output logic [31:0]       out_op_b,
    output logic [4:0]        out_rd,
    output logic              out_rd_wen,
    output logic [CTRL_W-1:0] out_ctrl,

    output logic [31:0]       busy_mask
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

`ifdef OPERAND_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [REG_AW-1:0] rd;
        logic              rd_wen;
        logic [CTRL_W-1:0] ctrl;
    } issue_t;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    issue_t           held_q, held_d;

    logic   byp_a_c, byp_b_c;
    logic   haz_a_c, haz_b_c, waw_c, stall_c;
    logic   accept_c, kill_c, rd_tracked_c;
    issue_t issue_c;

    assign rf_addr_a = in_rs1;
    assign rf_addr_b = in_rs2;

    // Hazard detection against the scoreboard; a writeback this cycle resolves WAW and, with bypass, RAW.
    always_comb begin
        byp_a_c      = BYPASS && wb_en && (wb_addr == in_rs1);
        byp_b_c      = BYPASS && wb_en && (wb_addr == in_rs2);
        haz_a_c      = (in_rs1 != REG_AW'(0)) && busy_q[in_rs1] && !byp_a_c;
        haz_b_c      = (in_rs2 != REG_AW'(0)) && busy_q[in_rs2] && !byp_b_c;
        rd_tracked_c = in_rd_wen && (in_rd != REG_AW'(0));
        waw_c        = rd_tracked_c && busy_q[in_rd] && !(wb_en && (wb_addr == in_rd));
        stall_c      = in_valid && (haz_a_c || haz_b_c || waw_c);
        in_ready     = !flush && !stall_c && (!out_valid_q || out_ready);
        accept_c     = in_valid && in_ready;
        kill_c       = flush && out_valid_q && held_q.rd_wen && (held_q.rd != REG_AW'(0));
    end

    // Operand selection: x0 reads as zero regardless of the register file.
    always_comb begin
        issue_c        = '0;
        issue_c.op_a   = (in_rs1 == REG_AW'(0)) ? XLEN'(0) : (byp_a_c ? wb_data : rf_data_a);
        issue_c.op_b   = (in_rs2 == REG_AW'(0)) ? XLEN'(0) : (byp_b_c ? wb_data : rf_data_b);
        issue_c.rd     = in_rd;
        issue_c.rd_wen = in_rd_wen;
        issue_c.ctrl   = in_ctrl;
    end

    // Scoreboard: clears from writeback and flush, a new issue's set takes priority.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (kill_c) begin
            busy_d[held_q.rd] = 1'b0;
        end
        if (accept_c && rd_tracked_c) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output register: flush beats both a new accept and the handoff to execute.
    always_comb begin
        out_valid_d = out_valid_q;
        held_d      = held_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_c) begin
            out_valid_d = 1'b1;
            held_d      = issue_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            held_q      <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            held_q      <= held_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_op_a   = held_q.op_a;
    assign out_op_b   = held_q.op_b;
    assign out_rd     = held_q.rd;
    assign out_rd_wen = held_q.rd_wen;
    assign out_ctrl   = held_q.ctrl;
    assign busy_mask  = busy_q;

endmodule
